// File: rtl/spi_master_ctrl_if.sv
// ----------------------------------------------------------------------------
// spi_master_ctrl_if
//
// Groups every non-clock signal of the byte-level SPI master sequencer into
// one bundle. The signals fall into three groups:
//   register side : start, tx_data (to controller); busy, done, rx_data (back)
//   shift register: sr_ld, sr_ld_data, sr_sh (to shift register);
//                   sr_dstr = {MISO, shr[7:1]} (from shift register)
//   SPI pins      : sck, ss_n (from controller)
//
// modport master : the sequencer itself (spi_master_ctrl)
// modport slave  : whatever surrounds it (register logic + shift register)
// ----------------------------------------------------------------------------
interface spi_master_ctrl_if;
    logic       start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       sr_ld;
    logic [7:0] sr_ld_data;
    logic       sr_sh;
    logic [7:0] sr_dstr;
    logic       sck;
    logic       ss_n;

    modport master (
        input  start, tx_data, sr_dstr,
        output busy, done, rx_data, sr_ld, sr_ld_data, sr_sh, sck, ss_n
    );

    modport slave (
        output start, tx_data, sr_dstr,
        input  busy, done, rx_data, sr_ld, sr_ld_data, sr_sh, sck, ss_n
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// ----------------------------------------------------------------------------
// spi_master_ctrl
//
// Byte-level SPI master sequencer (mode 0, LSB first, 8 bits per frame).
// It never touches MOSI/MISO: it only strobes an external 8-bit shift
// register (load / shift), generates SCK and active-low slave select, and
// latches the received byte from the shift register's parallel store output.
//
// Parameters:
//   DIV   SCK half-period in clk cycles (1..255)
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   spi_master_ctrl_if.master
//           start/tx_data in, busy/done/rx_data out,
//           sr_ld/sr_ld_data/sr_sh out, sr_dstr in, sck/ss_n out
// ----------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    spi_master_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOW,
        HIGH,
        HOLD,
        DONE
    } state_t;

    // Value of div_cnt on the final cycle of a LOW/HIGH/HOLD phase.
    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       phase_end;

    assign phase_end = (div_cnt_q == DIV_LAST);

    // State and counter registers. Reset aborts a frame on the spot, so the
    // partially shifted byte never reaches rx_data and no done pulse is
    // produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_cnt_q <= 8'h00;
            bit_cnt_q <= 3'd0;
            tx_buf_q  <= 8'h00;
            rx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_buf_q  <= tx_buf_d;
            rx_data_q <= rx_data_d;
        end
    end

    // Next-state logic and output decode. All outputs come from registered
    // state and counters only, so nothing here depends combinationally on
    // start. The shift strobe sits on the last HIGH cycle so the shift
    // register moves on the same clk edge where SCK falls; on the eighth
    // bit the parallel store value already contains the complete byte,
    // which is why rx_data is captured from sr_dstr in that same cycle.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_buf_d  = tx_buf_q;
        rx_data_d = rx_data_q;

        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.sr_ld = 1'b0;
        bus.sr_sh = 1'b0;
        bus.sck   = 1'b0;
        bus.ss_n  = 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tx_buf_d = bus.tx_data;
                    state_d  = LOAD;
                end
            end

            LOAD: begin
                bus.busy  = 1'b1;
                bus.sr_ld = 1'b1;
                bus.ss_n  = 1'b0;
                div_cnt_d = 8'h00;
                bit_cnt_d = 3'd0;
                state_d   = LOW;
            end

            LOW: begin
                bus.busy = 1'b1;
                bus.ss_n = 1'b0;
                if (phase_end) begin
                    div_cnt_d = 8'h00;
                    state_d   = HIGH;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            HIGH: begin
                bus.busy = 1'b1;
                bus.ss_n = 1'b0;
                bus.sck  = 1'b1;
                if (phase_end) begin
                    bus.sr_sh = 1'b1;
                    div_cnt_d = 8'h00;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d = bus.sr_dstr;
                        state_d   = HOLD;
                    end else begin
                        state_d   = LOW;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            HOLD: begin
                bus.busy = 1'b1;
                bus.ss_n = 1'b0;
                if (phase_end) begin
                    div_cnt_d = 8'h00;
                    state_d   = DONE;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.sr_ld_data = tx_buf_q;
    assign bus.rx_data    = rx_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ----------------------------------------------------------------------------
// tb_spi_master_ctrl
//
// Self-checking bench for spi_master_ctrl. Four controller instances run at
// DIV = 2, 3, 1 and 4 (instances 0..3). Each has its own behavioural 8-bit
// shift register (load, shift-right with MISO into bit 7, MOSI = bit 0) and
// a MOSI monitor sampling on SCK rising edges. Instance 1 talks to a slave
// model that drives a byte LSB first, changing MISO on SCK falling edges;
// the others loop MOSI back to MISO.
//
// Expected frames (done cycle, rx byte, decoded MOSI byte) are pushed to a
// queue when a transfer is started; every done pulse pushes the observed
// frame to a second queue, and each test pops and compares the two.
// ----------------------------------------------------------------------------
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [3:0] startA = 4'b0000;
    logic [7:0] txA [4] = '{default: 8'h00};
    logic [7:0] slaveByte = 8'h00;

    logic [3:0] busyA;
    logic [3:0] doneA;
    logic [3:0] ldA;
    logic [3:0] shA;
    logic [3:0] sckA;
    logic [3:0] ssnA;
    logic [7:0] rxA [4];
    logic [7:0] ldDataA [4];
    logic [7:0] monA [4];

    typedef struct {
        int         cycle;
        logic [7:0] rx;
        logic [7:0] mon;
    } frame_t;

    frame_t expQ [$];
    frame_t obsQ [$];
    int     ldCycles [$];

    int compared   = 0;
    int mismatched = 0;

    int shCount;
    int overlap;
    int ssFirst;
    int ssLast;
    int ssLowCount;
    int sckWhileIdle;
    int sckBad;
    int run;
    int pulses;
    int pulseBad;

    // One controller, shift register, MOSI monitor and MISO source per DIV.
    for (genvar i = 0; i < 4; i++) begin : g
        localparam int D = (i == 0) ? 2 : (i == 1) ? 3 : (i == 2) ? 1 : 4;

        spi_master_ctrl_if bus ();

        logic [7:0] shr;
        logic [7:0] mon;
        logic       mosi;
        logic       miso;

        spi_master_ctrl #(.DIV(D)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.master)
        );

        assign bus.start   = startA[i];
        assign bus.tx_data = txA[i];
        assign bus.sr_dstr = {miso, shr[7:1]};
        assign mosi        = shr[0];

        assign busyA[i]   = bus.busy;
        assign doneA[i]   = bus.done;
        assign ldA[i]     = bus.sr_ld;
        assign shA[i]     = bus.sr_sh;
        assign sckA[i]    = bus.sck;
        assign ssnA[i]    = bus.ss_n;
        assign rxA[i]     = bus.rx_data;
        assign ldDataA[i] = bus.sr_ld_data;
        assign monA[i]    = mon;

        if (i == 1) begin : slv
            logic [2:0] slaveIdx;

            // Slave presents bit 0 while selected and advances on each SCK fall.
            always @(negedge bus.sck or posedge bus.ss_n) begin
                if (bus.ss_n) slaveIdx <= 3'd0;
                else          slaveIdx <= slaveIdx + 3'd1;
            end

            assign miso = slaveByte[slaveIdx];
        end else begin : lb
            assign miso = mosi;
        end

        // Behavioural shift register stage driven by the controller strobes.
        always @(posedge clk) begin
            if (rst)             shr <= 8'h00;
            else if (bus.sr_ld)  shr <= bus.sr_ld_data;
            else if (bus.sr_sh)  shr <= {miso, shr[7:1]};
        end

        // MOSI decoder, LSB first, sampling on SCK rising edges.
        always @(posedge bus.sck) begin
            mon <= {mosi, mon[7:1]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearStats();
        expQ.delete();
        obsQ.delete();
        ldCycles.delete();
        shCount      = 0;
        overlap      = 0;
        ssFirst      = -1;
        ssLast       = -1;
        ssLowCount   = 0;
        sckWhileIdle = 0;
        sckBad       = 0;
        run          = 0;
        pulses       = 0;
        pulseBad     = 0;
    endtask

    // Records what instance k did in frame-relative cycle c.
    task automatic observe(input int k, input int c, input int div);
        if (shA[k]) shCount++;
        if (ldA[k]) begin
            ldCycles.push_back(c);
            if (sckA[k]) sckBad++;
        end
        if (ldA[k] && shA[k]) overlap++;
        if (!ssnA[k]) begin
            if (ssFirst < 0) ssFirst = c;
            ssLast = c;
            ssLowCount++;
        end
        if (sckA[k] && ssnA[k]) sckWhileIdle++;
        if (sckA[k]) begin
            run++;
        end else if (run > 0) begin
            pulses++;
            if (run != div) pulseBad++;
            run = 0;
        end
        if (c >= 2 + 16 * div && c <= 1 + 17 * div && sckA[k]) sckBad++;
        if (doneA[k]) begin
            obsQ.push_back('{c, rxA[k], monA[k]});
            if (sckA[k]) sckBad++;
        end
    endtask

    // Reset values on every instance, then an abort during HIGH of bit 3.
    task automatic test_reset();
        int doneSeen;
        int rxBad;
        rst = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            compared++;
            if ({busyA[k], doneA[k], ldA[k], shA[k], sckA[k], ssnA[k]} !== 6'b000001) begin
                mismatched++;
                $display("[TB] FAIL reset_ctrl[%0d]: got %b, expected 000001", k,
                         {busyA[k], doneA[k], ldA[k], shA[k], sckA[k], ssnA[k]});
            end
            compared++;
            if (rxA[k] !== 8'h00) begin
                mismatched++;
                $display("[TB] FAIL reset_rx[%0d]: got %h, expected 00", k, rxA[k]);
            end
            compared++;
            if (ldDataA[k] !== 8'h00) begin
                mismatched++;
                $display("[TB] FAIL reset_lddata[%0d]: got %h, expected 00", k, ldDataA[k]);
            end
        end
        rst = 1'b0;
        tick();

        clearStats();
        startA[0] = 1'b1;
        txA[0]    = 8'hC3;
        for (int c = 1; c <= 16; c++) begin
            tick();
            observe(0, c, 2);
            if (c == 1) startA[0] = 1'b0;
        end
        compared++;
        if ({sckA[0], busyA[0]} !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL abort_in_high: got sck/busy %b, expected 11", {sckA[0], busyA[0]});
        end
        rst = 1'b1;
        tick();
        compared++;
        if ({ssnA[0], sckA[0], busyA[0], doneA[0]} !== 4'b1000) begin
            mismatched++;
            $display("[TB] FAIL abort_state: got ss_n/sck/busy/done %b, expected 1000",
                     {ssnA[0], sckA[0], busyA[0], doneA[0]});
        end
        compared++;
        if (rxA[0] !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL abort_rx: got %h, expected 00", rxA[0]);
        end
        tick();
        rst = 1'b0;
        doneSeen = 0;
        rxBad    = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (doneA[0] !== 1'b0) doneSeen++;
            if (rxA[0] !== 8'h00) rxBad++;
        end
        compared++;
        if (doneSeen !== 0) begin
            mismatched++;
            $display("[TB] FAIL abort_no_done: got %0d done cycles, expected 0", doneSeen);
        end
        compared++;
        if (rxBad !== 0) begin
            mismatched++;
            $display("[TB] FAIL abort_rx_hold: got %0d bad rx cycles, expected 0", rxBad);
        end
    endtask

    // Loopback at DIV=2: exact LOAD/done/ss_n timing and strobe counts.
    task automatic test_loopback();
        clearStats();
        startA[0] = 1'b1;
        txA[0]    = 8'hA5;
        expQ.push_back('{36, 8'hA5, 8'hA5});
        for (int c = 1; c <= 40; c++) begin
            tick();
            observe(0, c, 2);
            if (c == 1) startA[0] = 1'b0;
            if (c == 37) begin
                compared++;
                if ({busyA[0], ssnA[0], doneA[0]} !== 3'b010) begin
                    mismatched++;
                    $display("[TB] FAIL loop_idle_37: got busy/ss_n/done %b, expected 010",
                             {busyA[0], ssnA[0], doneA[0]});
                end
            end
        end
        compared++;
        if (ldCycles.size() !== 1 || ldCycles[0] !== 1) begin
            mismatched++;
            $display("[TB] FAIL loop_load: got %0d loads (first at %0d), expected 1 at cycle 1",
                     ldCycles.size(), (ldCycles.size() > 0) ? ldCycles[0] : -1);
        end
        compared++;
        if (shCount !== 8 || overlap !== 0) begin
            mismatched++;
            $display("[TB] FAIL loop_shifts: got %0d shifts, %0d overlaps, expected 8, 0", shCount, overlap);
        end
        compared++;
        if (ssFirst !== 1 || ssLast !== 35 || ssLowCount !== 35) begin
            mismatched++;
            $display("[TB] FAIL loop_ss_n: got low %0d..%0d (%0d cycles), expected 1..35 (35)",
                     ssFirst, ssLast, ssLowCount);
        end
        compared++;
        if (obsQ.size() !== 1) begin
            mismatched++;
            $display("[TB] FAIL loop_done_count: got %0d, expected 1", obsQ.size());
        end
        while (expQ.size() > 0) begin
            frame_t e;
            frame_t o;
            e = expQ.pop_front();
            compared++;
            if (obsQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL loop_frame: got no frame, expected rx %h", e.rx);
            end else begin
                o = obsQ.pop_front();
                if (o.cycle !== e.cycle || o.rx !== e.rx || o.mon !== e.mon) begin
                    mismatched++;
                    $display("[TB] FAIL loop_frame: got cycle %0d rx %h mosi %h, expected cycle %0d rx %h mosi %h",
                             o.cycle, o.rx, o.mon, e.cycle, e.rx, e.mon);
                end
            end
        end
    endtask

    // Slave model at DIV=3: MISO byte 0x3C received while MOSI carries 0x5A.
    task automatic test_slave();
        clearStats();
        slaveByte = 8'h3C;
        startA[1] = 1'b1;
        txA[1]    = 8'h5A;
        expQ.push_back('{53, 8'h3C, 8'h5A});
        for (int c = 1; c <= 56; c++) begin
            tick();
            observe(1, c, 3);
            if (c == 1) startA[1] = 1'b0;
        end
        compared++;
        if (shCount !== 8 || overlap !== 0) begin
            mismatched++;
            $display("[TB] FAIL slave_shifts: got %0d shifts, %0d overlaps, expected 8, 0", shCount, overlap);
        end
        while (expQ.size() > 0) begin
            frame_t e;
            frame_t o;
            e = expQ.pop_front();
            compared++;
            if (obsQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL slave_frame: got no frame, expected rx %h", e.rx);
            end else begin
                o = obsQ.pop_front();
                if (o.cycle !== e.cycle || o.rx !== e.rx || o.mon !== e.mon) begin
                    mismatched++;
                    $display("[TB] FAIL slave_frame: got cycle %0d rx %h mosi %h, expected cycle %0d rx %h mosi %h",
                             o.cycle, o.rx, o.mon, e.cycle, e.rx, e.mon);
                end
            end
        end
    endtask

    // A second start while busy must be ignored completely.
    task automatic test_start_busy();
        clearStats();
        startA[0] = 1'b1;
        txA[0]    = 8'h66;
        expQ.push_back('{36, 8'h66, 8'h66});
        for (int c = 1; c <= 45; c++) begin
            tick();
            observe(0, c, 2);
            if (c == 1) startA[0] = 1'b0;
            if (c == 10) begin
                startA[0] = 1'b1;
                txA[0]    = 8'hFF;
            end
            if (c == 11) startA[0] = 1'b0;
        end
        compared++;
        if (obsQ.size() !== 1 || ldCycles.size() !== 1 || shCount !== 8) begin
            mismatched++;
            $display("[TB] FAIL busy_counts: got %0d done, %0d loads, %0d shifts, expected 1, 1, 8",
                     obsQ.size(), ldCycles.size(), shCount);
        end
        while (expQ.size() > 0) begin
            frame_t e;
            frame_t o;
            e = expQ.pop_front();
            compared++;
            if (obsQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL busy_frame: got no frame, expected rx %h", e.rx);
            end else begin
                o = obsQ.pop_front();
                if (o.cycle !== e.cycle || o.rx !== e.rx || o.mon !== e.mon) begin
                    mismatched++;
                    $display("[TB] FAIL busy_frame: got cycle %0d rx %h mosi %h, expected cycle %0d rx %h mosi %h",
                             o.cycle, o.rx, o.mon, e.cycle, e.rx, e.mon);
                end
            end
        end
    endtask

    // DIV=1 with start held high: two frames, each restarting from IDLE.
    task automatic test_back_to_back();
        clearStats();
        startA[2] = 1'b1;
        txA[2]    = 8'h01;
        expQ.push_back('{19, 8'h01, 8'h01});
        expQ.push_back('{39, 8'h80, 8'h80});
        for (int c = 1; c <= 45; c++) begin
            tick();
            observe(2, c, 1);
            if (c == 1) txA[2] = 8'h80;
            if (c == 20) begin
                compared++;
                if ({busyA[2], ssnA[2]} !== 2'b01) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_idle_20: got busy/ss_n %b, expected 01", {busyA[2], ssnA[2]});
                end
            end
            if (c == 21) startA[2] = 1'b0;
        end
        compared++;
        if (ldCycles.size() !== 2 || ldCycles[0] !== 1 || ldCycles[1] !== 21) begin
            mismatched++;
            $display("[TB] FAIL b2b_loads: got %0d loads, expected 2 at cycles 1 and 21", ldCycles.size());
        end
        compared++;
        if (shCount !== 16 || overlap !== 0 || pulseBad !== 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_shifts: got %0d shifts, %0d overlaps, %0d bad pulses, expected 16, 0, 0",
                     shCount, overlap, pulseBad);
        end
        while (expQ.size() > 0) begin
            frame_t e;
            frame_t o;
            e = expQ.pop_front();
            compared++;
            if (obsQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL b2b_frame: got no frame, expected rx %h", e.rx);
            end else begin
                o = obsQ.pop_front();
                if (o.cycle !== e.cycle || o.rx !== e.rx || o.mon !== e.mon) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_frame: got cycle %0d rx %h mosi %h, expected cycle %0d rx %h mosi %h",
                             o.cycle, o.rx, o.mon, e.cycle, e.rx, e.mon);
                end
            end
        end
    endtask

    // DIV=4: eight SCK pulses of exactly 4 cycles, SCK quiet outside bits.
    task automatic test_sck_shape();
        clearStats();
        startA[3] = 1'b1;
        txA[3]    = 8'h9C;
        expQ.push_back('{70, 8'h9C, 8'h9C});
        for (int c = 1; c <= 74; c++) begin
            tick();
            observe(3, c, 4);
            if (c == 1) startA[3] = 1'b0;
        end
        compared++;
        if (pulses !== 8 || pulseBad !== 0) begin
            mismatched++;
            $display("[TB] FAIL sck_pulses: got %0d pulses, %0d wrong width, expected 8, 0", pulses, pulseBad);
        end
        compared++;
        if (sckBad !== 0 || sckWhileIdle !== 0) begin
            mismatched++;
            $display("[TB] FAIL sck_quiet: got %0d in load/hold/done, %0d while deselected, expected 0, 0",
                     sckBad, sckWhileIdle);
        end
        compared++;
        if (shCount !== 8) begin
            mismatched++;
            $display("[TB] FAIL sck_shifts: got %0d, expected 8", shCount);
        end
        while (expQ.size() > 0) begin
            frame_t e;
            frame_t o;
            e = expQ.pop_front();
            compared++;
            if (obsQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL sck_frame: got no frame, expected rx %h", e.rx);
            end else begin
                o = obsQ.pop_front();
                if (o.cycle !== e.cycle || o.rx !== e.rx || o.mon !== e.mon) begin
                    mismatched++;
                    $display("[TB] FAIL sck_frame: got cycle %0d rx %h mosi %h, expected cycle %0d rx %h mosi %h",
                             o.cycle, o.rx, o.mon, e.cycle, e.rx, e.mon);
                end
            end
        end
    endtask

    // Test sequence.
    initial begin
        $display("[TB] spi_master_ctrl bench starting");
        test_reset();
        test_loopback();
        test_slave();
        test_start_busy();
        test_back_to_back();
        test_sck_shape();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Byte-level SPI master sequencer that drives the 8-bit shift register stage of the Wishbone–SPI interface. It accepts a byte and a start strobe from the Wishbone-side register logic. It pulses the shift register's load and shift controls, generates SCK and the active-low slave select, and latches the received byte from the shift register's parallel store output. The controller never touches MOSI or MISO directly: the shift register's serial output drives MOSI, and MISO drives the shift register's serial input. The frame format is SPI mode 0 (CPOL=0, CPHA=0), LSB first, 8 bits per frame.

## Interface
Parameters:
- DIV, 2, SCK half-period in clk cycles; legal range 1..255.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high.
- start  input  1  transfer request; sampled only in IDLE.
- tx_data  input  8  byte to send; captured in the same cycle start is accepted.
- busy  output  1  high from LOAD through HOLD.
- done  output  1  one-cycle pulse when the frame completes.
- rx_data  output  8  last received byte; holds its value until the next completed frame.
- sr_ld  output  1  shift register load strobe.
- sr_ld_data  output  8  byte presented to the shift register load input (the captured tx_data).
- sr_sh  output  1  shift register shift strobe.
- sr_dstr  input  8  shift register parallel store value: {MISO, shr[7:1]}.
- sck  output  1  SPI clock; idles low.
- ss_n  output  1  slave select, active low.

## Operation
- States: IDLE, LOAD, LOW, HIGH, HOLD, DONE.
- Internal counters:
  - div_cnt: 8-bit counter of elapsed cycles in the current phase.
  - bit_cnt: 3-bit counter of completed bits, wrapping 7→0.
- IDLE: ss_n=1, sck=0, busy=0. If start=1, capture tx_data into the tx buffer and go to LOAD.
- LOAD (1 cycle): sr_ld=1, sr_ld_data=tx buffer, ss_n=0. Clear div_cnt and bit_cnt, then go to LOW.
- LOW (DIV cycles): sck=0, ss_n=0. After DIV cycles, go to HIGH.
- HIGH (DIV cycles): sck=1, ss_n=0.
  - On the last HIGH cycle, sr_sh=1, so the shift register shifts at the same edge where sck falls.
  - If bit_cnt=7: latch rx_data←sr_dstr in that same cycle, then go to HOLD.
  - Otherwise: increment bit_cnt and go to LOW.
- HOLD (DIV cycles): sck=0, ss_n=0; this is the SS hold time after the last edge. Then go to DONE.
- DONE (1 cycle): done=1, ss_n=1, busy=0. Then go to IDLE.
- start is ignored in every state except IDLE, including DONE. start held high produces back-to-back frames, each beginning from IDLE.
- sr_ld and sr_sh are never asserted in the same cycle. sr_sh is asserted exactly 8 times per frame.
- rx_data updates only in the final HIGH cycle of a frame. An aborted frame leaves rx_data unchanged.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE. From there:
  - LOAD: cycle 1.
  - Bit n LOW phase: cycles 2+2n·DIV … 1+(2n+1)·DIV.
  - Bit n HIGH phase: the next DIV cycles.
  - HOLD: cycles 2+16·DIV … 1+17·DIV.
  - DONE: cycle 2+17·DIV.
- With DIV=2, done is high in cycle 36 and the controller returns to IDLE in cycle 37.
- All outputs are decoded from registered state and counters, so no output depends combinationally on start.
- rx_data is valid from the cycle after the final sr_sh; it is already stable while done=1.
- DIV=1: each phase lasts 1 cycle, and SCK runs at clk/2.
- Reset values, applied on the first clk edge with rst=1:
  - State returns to IDLE.
  - busy=0, done=0, sr_ld=0, sr_sh=0, sck=0, ss_n=1.
  - rx_data=0x00, sr_ld_data=0x00.
  - div_cnt=0, bit_cnt=0.
- Reset mid-frame aborts immediately with the same values: no done pulse, and the partial byte is discarded.

## Test plan
- Reset: assert rst for 2 cycles during HIGH of bit 3 -> next cycle ss_n=1, sck=0, busy=0, done never pulses, rx_data=0x00.
- Loopback, DIV=2: connect the shift register's serial output to its serial input, then tx_data=0xA5 with start in cycle 0.
  - sr_ld is high in cycle 1.
  - Exactly 8 sr_sh pulses occur.
  - done is high in cycle 36 with rx_data=0xA5.
  - ss_n is low in cycles 1–35.
- Slave model, DIV=3: the slave drives 0x3C LSB first, changing MISO on sck falling edges -> rx_data=0x3C at done; a MOSI monitor sampling on sck rising edges decodes tx_data=0x5A.
- Start during busy: pulse start again in cycle 10 with tx_data=0xFF -> ignored; the frame completes with the original byte and only one done pulse.
- Back-to-back, DIV=1: hold start=1 with tx_data=0x01, then 0x80 -> done pulses in cycle 19; IDLE in cycle 20; the second LOAD is in cycle 21; the second rx_data matches the loopback.
- SCK shape, DIV=4: measure over a frame -> 8 high pulses of exactly 4 cycles, sck low in LOAD/HOLD/DONE, and no sck edge while ss_n=1.
